// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer: FSM encoding, golden
// vector default and the combinational function under test.
package truth_table_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_APPLY   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_WAIT    = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam logic [7:0] GOLDEN_DEFAULT = 8'h7E;
   localparam logic [2:0] LAST_INDEX     = 3'd7;

   // stim = {s2, s1, s0}
   function automatic logic fut(input logic [2:0] stim);
      return (~stim[0] & (stim[1] | stim[2])) | (stim[0] & ~(stim[1] & stim[2]));
   endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Front-panel bundle for the sequencer: push-buttons and switches in, LEDs out.
interface truth_table_sequencer_if;
   logic        start;
   logic        step;
   logic [7:0]  sw;
   logic [15:0] led;

   modport master (output start, output step, output sw, input led);
   modport slave  (input start, input step, input sw, output led);
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, then a single-cycle pulse
// once the synchronised level has been high for DEBOUNCE_CYC cycles.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic srst,
   input  logic raw,
   output logic pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic [1:0]    sync_reg;
   logic [CW-1:0] cnt_reg;
   logic          pulse_reg;

   // The counter saturates at DEBOUNCE_CYC so a held button fires only once.
   always_ff @(posedge clk) begin
      if (srst) begin
         sync_reg  <= '0;
         cnt_reg   <= '0;
         pulse_reg <= 1'b0;
      end else begin
         sync_reg  <= {sync_reg[0], raw};
         pulse_reg <= sync_reg[1] && (cnt_reg == CW'(DEBOUNCE_CYC - 1));
         if (!sync_reg[1])
            cnt_reg <= '0;
         else if (cnt_reg != CW'(DEBOUNCE_CYC))
            cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign pulse = pulse_reg;
endmodule

// File: rtl/truth_table_sequencer.sv
// Steps a 3-bit stimulus through all eight rows, captures f per row into a
// truth vector and compares it against GOLDEN; auto or button-stepped mode.
module truth_table_sequencer
   import truth_table_sequencer_pkg::*;
#(
   parameter int         STEP_DIV     = 50_000_000,
   parameter int         DEBOUNCE_CYC = 1_000_000,
   parameter int         SETTLE_CYC   = 4,
   parameter logic [7:0] GOLDEN       = GOLDEN_DEFAULT
) (
   input  logic        clk_pin,
   input  logic        rst_pin,
   input  logic        start_pin,
   input  logic        step_pin,
   input  logic [7:0]  sw_pin,
   output logic [15:0] led_pin
);
   localparam int CNT_MAX = (STEP_DIV > SETTLE_CYC) ? STEP_DIV : SETTLE_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic [2:0]    index_reg, stim_reg;
   logic [7:0]    vector_reg, vec_cap;
   logic          pass_reg, fail_reg, done_reg, busy_reg, auto_reg;
   logic          start_p, step_p, f, auto_mode, auto_rise;
   logic          unused_sw;

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
      .clk(clk_pin), .srst(rst_pin), .raw(start_pin), .pulse(start_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_db (
      .clk(clk_pin), .srst(rst_pin), .raw(step_pin), .pulse(step_p));

   assign f         = fut(stim_reg);
   assign auto_mode = sw_pin[7];
   assign auto_rise = auto_mode & ~auto_reg;
   assign unused_sw = ^sw_pin[6:0];

   // Truth vector with the current row's result merged in.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_cap
         assign vec_cap[gi] = (index_reg == 3'(gi)) ? f : vector_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE: if (start_p) state_next = ST_APPLY;
         ST_APPLY:         state_next = ST_SETTLE;
         ST_SETTLE:        if (cnt_reg == CW'(SETTLE_CYC - 1)) state_next = ST_CAPTURE;
         ST_CAPTURE:       state_next = (index_reg == LAST_INDEX) ? ST_DONE : ST_WAIT;
         ST_WAIT: begin
            // A fresh switch to auto restarts the dwell rather than leaving.
            if (auto_mode ? (!auto_rise && cnt_reg == CW'(STEP_DIV - 1)) : step_p)
               state_next = ST_APPLY;
         end
         default:          state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_pin) begin
      if (rst_pin) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         index_reg  <= '0;
         stim_reg   <= '0;
         vector_reg <= '0;
         pass_reg   <= 1'b0;
         fail_reg   <= 1'b0;
         done_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         auto_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         auto_reg  <= auto_mode;
         busy_reg  <= (state_next == ST_APPLY) || (state_next == ST_SETTLE) ||
                      (state_next == ST_CAPTURE) || (state_next == ST_WAIT);
         done_reg  <= (state_next == ST_DONE);

         if ((state_next != state_reg) || (state_reg == ST_WAIT && auto_rise))
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + 1'b1;

         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start_p) begin
                  index_reg  <= '0;
                  vector_reg <= '0;
                  pass_reg   <= 1'b0;
                  fail_reg   <= 1'b0;
               end
            end
            ST_APPLY:   stim_reg <= index_reg;
            ST_CAPTURE: begin
               vector_reg <= vec_cap;
               if (index_reg == LAST_INDEX) begin
                  pass_reg <= (vec_cap == GOLDEN);
                  fail_reg <= (vec_cap != GOLDEN);
               end
            end
            ST_WAIT:    if (state_next == ST_APPLY) index_reg <= index_reg + 1'b1;
            default:    ;
         endcase
      end
   end

   assign led_pin = {vector_reg, fail_reg, pass_reg, busy_reg, done_reg, f, stim_reg};
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with short timing parameters;
// a second instance with GOLDEN=8'h7F exercises the mismatch path.
module tb_truth_table_sequencer;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] led_b;
   int          total = 0;
   int          bad   = 0;

   truth_table_sequencer_if bus ();

   always #5 clk = ~clk;

   truth_table_sequencer #(.STEP_DIV(8), .DEBOUNCE_CYC(4), .SETTLE_CYC(2)) dut (
      .clk_pin(clk), .rst_pin(rst), .start_pin(bus.start), .step_pin(bus.step),
      .sw_pin(bus.sw), .led_pin(bus.led));

   truth_table_sequencer #(.STEP_DIV(8), .DEBOUNCE_CYC(4), .SETTLE_CYC(2),
                           .GOLDEN(8'h7F)) dut_b (
      .clk_pin(clk), .rst_pin(rst), .start_pin(bus.start), .step_pin(bus.step),
      .sw_pin(bus.sw), .led_pin(led_b));

   // Waits (bounded) until led bit `idx` equals `val`; caller compares `ok`.
   task automatic wait_led(input int idx, input logic val, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         if (bus.led[idx] === val) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic hold_start(input int cycles);
      bus.start = 1'b1;
      repeat (cycles) @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Full auto sweep from the first busy cycle; rows every 12 cycles.
   task automatic auto_sweep_check(input string tag);
      bit ok;
      logic [7:0] golden_f;
      golden_f = 8'h7E;
      wait_led(5, 1'b1, 40, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL %s_start: busy got 0 want 1 within 40 cycles", tag);
         return;
      end
      for (int c = 0; c <= 88; c++) begin
         if (c % 12 == 1) begin
            total++;
            if (bus.led[2:0] !== 3'(c / 12)) begin
               bad++;
               $display("FAIL %s_stim c=%0d: got %0d want %0d", tag, c, bus.led[2:0], c / 12);
            end
         end
         if (c % 12 == 0 && c > 0 && c <= 84) begin
            total++;
            if (bus.led[2:0] !== 3'(c / 12 - 1)) begin
               bad++;
               $display("FAIL %s_dwell c=%0d: got %0d want %0d", tag, c, bus.led[2:0], c / 12 - 1);
            end
         end
         if (c % 12 == 2) begin
            total++;
            if (bus.led[3] !== golden_f[c / 12]) begin
               bad++;
               $display("FAIL %s_f row=%0d: got %b want %b", tag, c / 12, bus.led[3], golden_f[c / 12]);
            end
         end
         if (c == 87) begin
            total++;
            if (bus.led[5:4] !== 2'b10) begin
               bad++;
               $display("FAIL %s_capture7: busy/done got %b want 10", tag, bus.led[5:4]);
            end
         end
         if (c == 88) begin
            total++;
            if (bus.led[15:4] !== {8'h7E, 4'b0101}) begin
               bad++;
               $display("FAIL %s_done: led[15:4] got %h want %h", tag, bus.led[15:4], {8'h7E, 4'b0101});
            end
         end
         if (c < 88) @(negedge clk);
      end
      $display("%s: sweep finished led=%h", tag, bus.led);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.step  = 1'b0;
      bus.sw    = 8'h00;
      repeat (3) @(negedge clk);
      total++;
      if (bus.led !== 16'h0000) begin
         bad++;
         $display("FAIL reset_hold: led got %h want 0000", bus.led);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (bus.led !== 16'h0000 || led_b !== 16'h0000) begin
         bad++;
         $display("FAIL reset_release: led got %h/%h want 0000", bus.led, led_b);
      end
      $display("test_reset: led=%h", bus.led);
   endtask

   task automatic test_auto_sweep();
      bus.sw = 8'h80;
      fork
         hold_start(10);
         auto_sweep_check("auto");
      join
   endtask

   task automatic test_ignored_inputs();
      bus.sw = 8'h80;
      fork
         hold_start(10);
         auto_sweep_check("ignored");
         begin
            repeat (30) @(negedge clk);
            hold_start(10);
            repeat (10) @(negedge clk);
            bus.step = 1'b1;
            repeat (10) @(negedge clk);
            bus.step = 1'b0;
         end
      join
   endtask

   task automatic test_manual_sweep();
      bit ok;
      logic [7:0] exp_vec;
      bus.sw = 8'h00;
      fork
         hold_start(10);
         wait_led(5, 1'b1, 40, ok);
      join
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL manual_start: busy got 0 want 1 within 40 cycles");
         return;
      end
      repeat (20) @(negedge clk);
      total++;
      if (bus.led[15:0] !== 16'h0020) begin
         bad++;
         $display("FAIL manual_row0_hold: led got %h want 0020", bus.led);
      end
      for (int r = 1; r <= 7; r++) begin
         bus.step = 1'b1;
         repeat (10) @(negedge clk);
         bus.step = 1'b0;
         for (int i = 0; i < 30 && bus.led[2:0] !== 3'(r); i++) @(negedge clk);
         repeat (20) @(negedge clk);
         exp_vec = 8'h7E & 8'((1 << (r + 1)) - 1);
         total++;
         if (bus.led[2:0] !== 3'(r) || bus.led[15:8] !== exp_vec) begin
            bad++;
            $display("FAIL manual_row%0d: stim/vec got %0d/%h want %0d/%h",
                     r, bus.led[2:0], bus.led[15:8], r, exp_vec);
         end
         $display("manual: step %0d led=%h", r, bus.led);
      end
      total++;
      if (bus.led[7:4] !== 4'b0101) begin
         bad++;
         $display("FAIL manual_done: fail/pass/busy/done got %b want 0101", bus.led[7:4]);
      end
   endtask

   task automatic test_bounce();
      bit ok;
      int rises;
      logic prev_busy;
      bus.sw = 8'h80;
      hold_start(3);
      repeat (20) @(negedge clk);
      total++;
      if (bus.led[5:4] !== 2'b01) begin
         bad++;
         $display("FAIL bounce_glitch: busy/done got %b want 01", bus.led[5:4]);
      end
      rises = 0;
      prev_busy = bus.led[5];
      fork
         hold_start(10);
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.led[5] === 1'b1 && prev_busy === 1'b0) rises++;
            prev_busy = bus.led[5];
         end
      join
      total++;
      if (rises !== 1) begin
         bad++;
         $display("FAIL bounce_sweeps: got %0d want 1", rises);
      end
      wait_led(4, 1'b1, 0, ok);
      total++;
      if (ok !== 1'b1) begin
         bad++;
         $display("FAIL bounce_done: done got %b want 1", bus.led[4]);
      end
      $display("test_bounce: sweeps=%0d led=%h", rises, bus.led);
   endtask

   task automatic test_reset_mid_sweep();
      bit found;
      bus.sw = 8'h80;
      found = 1'b0;
      fork
         hold_start(10);
         for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.led[5] === 1'b1 && bus.led[2:0] === 3'd4) begin
               found = 1'b1;
               break;
            end
         end
      join
      total++;
      if (found !== 1'b1) begin
         bad++;
         $display("FAIL midreset_reach: stim got %0d want 4", bus.led[2:0]);
         return;
      end
      repeat (4) @(negedge clk);
      total++;
      if (bus.led[15:8] !== 8'h1E || bus.led[5:4] !== 2'b10 || bus.led[2:0] !== 3'd4) begin
         bad++;
         $display("FAIL midreset_wait: led got %h want 1e2c", bus.led);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (bus.led !== 16'h0000) begin
         bad++;
         $display("FAIL midreset_clear: led got %h want 0000", bus.led);
      end
      rst = 1'b0;
      repeat (20) @(negedge clk);
      total++;
      if (bus.led !== 16'h0000) begin
         bad++;
         $display("FAIL midreset_idle: led got %h want 0000", bus.led);
      end
      $display("test_reset_mid_sweep: led=%h", bus.led);
   endtask

   task automatic test_mismatch();
      bit ok;
      bus.sw = 8'h80;
      fork
         hold_start(10);
         wait_led(4, 1'b1, 150, ok);
      join
      total++;
      if (ok !== 1'b1 || led_b[7:4] !== 4'b1001 || led_b[15:8] !== 8'h7E) begin
         bad++;
         $display("FAIL mismatch_first: led_b got %h want 7e9x", led_b);
      end
      fork
         hold_start(10);
         wait_led(5, 1'b1, 40, ok);
      join
      total++;
      if (ok !== 1'b1 || led_b[7:6] !== 2'b00 || bus.led[7:6] !== 2'b00) begin
         bad++;
         $display("FAIL mismatch_restart: pass/fail got %b/%b want 00/00", led_b[7:6], bus.led[7:6]);
      end
      wait_led(4, 1'b1, 150, ok);
      total++;
      if (ok !== 1'b1 || led_b[7:4] !== 4'b1001 || bus.led[7:4] !== 4'b0101) begin
         bad++;
         $display("FAIL mismatch_second: led_b/led got %h/%h want fail/pass", led_b, bus.led);
      end
      $display("test_mismatch: led=%h led_b=%h", bus.led, led_b);
   endtask

   initial begin
      test_reset();
      test_auto_sweep();
      test_ignored_inputs();
      test_manual_sweep();
      test_bounce();
      test_reset_mid_sweep();
      test_mismatch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
